// File: rtl/vga_fb_pkg.sv
// Shared constants for the VGA framebuffer reader.
// RAM source-select encoding matches the memory controller's control constants.
// FSM state encoding and the pixels-per-word helper live here.
// The optional underrun detector in vga_fb_reader is enabled by VGA_FB_UNDERRUN_EN.
package vga_fb_pkg;

    // RAM source select, shared with the memory controller
    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_VGA = 1'b1;

    // Reader FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Default geometry: 32-bit words of 4-bit pixels
    localparam int DEF_WORD_SIZE = 32;
    localparam int DEF_PIX_BITS  = 4;
    localparam int PIX_PER_WORD  = DEF_WORD_SIZE / DEF_PIX_BITS;

    // Pixels carried by one RAM word for an arbitrary geometry
    function automatic int pix_per_word(input int word_size, input int pix_bits);
        return word_size / pix_bits;
    endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// Two-entry word FIFO between the RAM read return and the pixel shifter.
// Supports flush, and a simultaneous push+pop while full (the slot being
// popped is the one refilled on the next write pointer position).
module fb_word_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [0:1];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush discards all stored words
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/vga_fb_reader.sv
// VGA-side requester for the shared framebuffer RAM.
// Issues word reads over the VGA port, captures the data one cycle later,
// buffers up to two words, and unpacks them LSB-first into a ready/valid
// pixel stream. Optional sticky underrun flag: define VGA_FB_UNDERRUN_EN.
//
// Handshake: a pixel moves on a cycle where pix_valid and pix_ready are both
// high; pix_data is held while pix_valid=1 and pix_ready=0. A RAM issue occurs
// on a cycle with bus_req=1 and bus_gnt=1; bus_gnt alone is ignored.
module vga_fb_reader
    import vga_fb_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 9,
    parameter int PIX_BITS  = 4,
    parameter int FB_BASE   = 0,
    parameter int FB_WORDS  = 256
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 frame_start,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic                 src,
    output logic [ADDR_W-1:0]    vga_addr,
    input  logic [WORD_SIZE-1:0] rd,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [PIX_BITS-1:0]  pix_data,
    output logic                 frame_done,
    output logic                 underrun,
    output logic [1:0]           dbg_state
);

    localparam int PPW    = pix_per_word(WORD_SIZE, PIX_BITS);
    localparam int IDX_W  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int WIDX_W = ADDR_W + 1;

    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(FB_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(FB_BASE);
    localparam logic [IDX_W-1:0]  LAST_PIX  = IDX_W'(PPW - 1);

    logic [1:0]           state;
    logic [WIDX_W-1:0]    word_idx;
    logic                 inflight;
    logic [WORD_SIZE-1:0] sh_word;
    logic [IDX_W-1:0]     sh_idx;
    logic                 sh_loaded;

    logic [WORD_SIZE-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;

    logic [2:0]           occupancy;
    logic                 issue;
    logic                 xfer;
    logic                 last_pix;
    logic                 need_load;
    logic                 rd_ret;
    logic                 bypass;
    logic                 frame_end;

    // A word counts as outstanding from issue until its last pixel leaves the shifter
    assign occupancy = (fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1))
                     + {2'b00, inflight} + {2'b00, sh_loaded};

    assign bus_req   = (state == ST_FETCH) && (occupancy < 3'd3);
    assign issue     = bus_req && bus_gnt;
    assign src       = issue ? SRC_VGA : SRC_CPU;
    assign vga_addr  = BASE + word_idx[ADDR_W-1:0];

    assign pix_valid = sh_loaded;
    assign pix_data  = sh_word[PIX_BITS-1:0];
    assign xfer      = sh_loaded && pix_ready;
    assign last_pix  = xfer && (sh_idx == LAST_PIX);
    assign need_load = !sh_loaded || last_pix;

    // A return coinciding with frame_start belongs to the aborted frame
    assign rd_ret    = inflight && !frame_start;
    assign fifo_pop  = !frame_start && need_load && !fifo_empty;
    assign bypass    = !frame_start && need_load && fifo_empty && rd_ret;
    assign fifo_push = rd_ret && !bypass;

    // Last pixel of the frame: nothing buffered or in flight behind it
    assign frame_end = (state == ST_DRAIN) && last_pix && fifo_empty
                     && !inflight && !frame_start;

    assign dbg_state = state;

    fb_word_fifo #(
        .W(WORD_SIZE)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (frame_start),
        .push   (fifo_push),
        .wdata  (rd),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Frame FSM, word counter and read-in-flight flag; frame_start restarts from any state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            word_idx <= '0;
            inflight <= 1'b0;
        end else if (frame_start) begin
            state    <= ST_FETCH;
            word_idx <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            case (state)
                ST_FETCH: begin
                    if (issue) begin
                        word_idx <= word_idx + WIDX_W'(1);
                        if (word_idx == LAST_WORD) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (frame_end) begin
                        state    <= ST_IDLE;
                        word_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // End-of-frame pulse, one cycle after the final pixel transfer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) frame_done <= 1'b0;
        else         frame_done <= frame_end;
    end

    // Pixel shifter: reload from FIFO (or straight from rd) without a bubble
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh_word   <= '0;
            sh_idx    <= '0;
            sh_loaded <= 1'b0;
        end else if (frame_start) begin
            sh_word   <= '0;
            sh_idx    <= '0;
            sh_loaded <= 1'b0;
        end else if (need_load) begin
            if (!fifo_empty) begin
                sh_word   <= fifo_rdata;
                sh_idx    <= '0;
                sh_loaded <= 1'b1;
            end else if (rd_ret) begin
                sh_word   <= rd;
                sh_idx    <= '0;
                sh_loaded <= 1'b1;
            end else if (last_pix) begin
                sh_loaded <= 1'b0;
            end
        end else if (xfer) begin
            sh_word <= sh_word >> PIX_BITS;
            sh_idx  <= sh_idx + IDX_W'(1);
        end
    end

`ifdef VGA_FB_UNDERRUN_EN
    // Sticky underrun: consumer ready with no pixel while a frame is active
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                        underrun <= 1'b0;
        else if (frame_start)                               underrun <= 1'b0;
        else if ((state != ST_IDLE) && pix_ready && !sh_loaded) underrun <= 1'b1;
    end
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader with a 4-word frame and a behavioural RAM.
module tb_vga_fb_reader;
    import vga_fb_pkg::*;

    localparam int FB_WORDS = 4;
    localparam int FB_BASE  = 0;
    localparam int PPW      = 8;
    localparam int TOTAL    = FB_WORDS * PPW;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic        src;
    logic [8:0]  vga_addr;
    logic [31:0] rd;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [3:0]  pix_data;
    logic        frame_done;
    logic        underrun;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:511];
    logic [8:0]  ret_addr = '0;

    logic [3:0]  exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_addr = 0;
    int          n_issues = 0;
    int          n_xfer = 0;
    bit          done_next = 0;
    bit          seen_done = 0;
    bit          abort_pending = 0;
    bit          hold_pending = 0;
    logic [3:0]  held_data = '0;

    vga_fb_reader #(
        .WORD_SIZE (32),
        .ADDR_W    (9),
        .PIX_BITS  (4),
        .FB_BASE   (FB_BASE),
        .FB_WORDS  (FB_WORDS)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_start (frame_start),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .src         (src),
        .vga_addr    (vga_addr),
        .rd          (rd),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .frame_done  (frame_done),
        .underrun    (underrun),
        .dbg_state   (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // RAM model: address latched on a VGA issue, data visible the next cycle
    always @(posedge clk) begin
        if (src == SRC_VGA) ret_addr <= vga_addr;
    end
    assign rd = mem[ret_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard/monitor: called after inputs for the coming edge are applied
    task automatic observe();
        int consumed;
        check("frame_done", {31'b0, frame_done}, {31'b0, done_next});
        if (frame_done) seen_done = 1;
        done_next = 0;
        check("src", {31'b0, src}, {31'b0, bus_req & bus_gnt});
        if (abort_pending) check("abort_valid", {31'b0, pix_valid}, 32'd0);
        abort_pending = 0;
        if (hold_pending) begin
            check("hold_valid", {31'b0, pix_valid}, 32'd1);
            check("hold_data", {28'b0, pix_data}, {28'b0, held_data});
        end
        hold_pending = 0;
`ifndef VGA_FB_UNDERRUN_EN
        check("underrun_off", {31'b0, underrun}, 32'd0);
`endif
        if (frame_start) begin
            exp_q.delete();
            for (int w = 0; w < FB_WORDS; w++)
                for (int p = 0; p < PPW; p++)
                    exp_q.push_back(mem[w + FB_BASE][p*4 +: 4]);
            exp_addr = 0;
            n_issues = 0;
            n_xfer = 0;
            seen_done = 0;
            abort_pending = 1;
            return;
        end
        if (src == SRC_VGA) begin
            check("issue_addr", {23'b0, vga_addr}, 32'(FB_BASE + exp_addr));
            exp_addr++;
            n_issues++;
        end else if (bus_req) begin
            check("addr_hold", {23'b0, vga_addr}, 32'(FB_BASE + exp_addr));
        end
        if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) check("extra_pixel", 32'd1, 32'd0);
            else check("pix_data", {28'b0, pix_data}, {28'b0, exp_q.pop_front()});
            n_xfer++;
            if (n_xfer == TOTAL) done_next = 1;
        end else if (pix_valid) begin
            hold_pending = 1;
            held_data = pix_data;
        end
        consumed = n_xfer / PPW;
        check("outstanding", {31'b0, (n_issues - consumed) <= 3}, 32'd1);
    endtask

    // Driver: apply inputs at the falling edge, then monitor
    task automatic step(input logic start, input logic gnt, input logic rdy);
        @(negedge clk);
        frame_start = start;
        bus_gnt = gnt;
        pix_ready = rdy;
        #1;
        observe();
    endtask

    // mode 0: free-running, 1: grant toggling 1-0-1, 2: consumer stall
    task automatic run_frame(input int mode, input int abort_at);
        bit aborted;
        logic g, r, s;
        aborted = 0;
        step(1'b1, 1'b1, 1'b1);
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            g = 1'b1;
            r = 1'b1;
            s = 1'b0;
            if (mode == 1) g = (cyc % 3 != 1);
            if (mode == 2 && cyc >= 5 && cyc < 25) r = 1'b0;
            if (abort_at > 0 && !aborted && n_issues == abort_at) begin
                s = 1'b1;
                aborted = 1;
            end
            step(s, g, r);
            if (mode == 2 && cyc == 24) check("stall_req_low", {31'b0, bus_req}, 32'd0);
        end
        step(1'b0, 1'b1, 1'b1);
        check("frame_complete", {31'b0, seen_done}, 32'd1);
        check("pixels_left", 32'(exp_q.size()), 32'd0);
        check("issue_total", 32'(n_issues), 32'(FB_WORDS));
        check("back_to_idle", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    endtask

    // Main sequence
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        mem[0] = 32'h7654_3210;
        mem[1] = 32'hFEDC_BA98;
        mem[2] = 32'h1357_9BDF;
        mem[3] = 32'h0246_8ACE;

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Idle: grant wiggled and consumer ready, nothing may move
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus_gnt = i[0];
            pix_ready = i[1];
            #1;
            check("idle_pix_valid", {31'b0, pix_valid}, 32'd0);
            check("idle_pix_data", {28'b0, pix_data}, 32'd0);
            check("idle_frame_done", {31'b0, frame_done}, 32'd0);
            check("idle_bus_req", {31'b0, bus_req}, 32'd0);
            check("idle_src", {31'b0, src}, {31'b0, SRC_CPU});
            check("idle_addr", {23'b0, vga_addr}, 32'(FB_BASE));
            check("idle_underrun", {31'b0, underrun}, 32'd0);
            check("idle_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        end

        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(2, 0);
        run_frame(0, 2);

        // Starved frame: no grant while the consumer is ready
        step(1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b1);
`ifdef VGA_FB_UNDERRUN_EN
        check("underrun_set", {31'b0, underrun}, 32'd1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        check("underrun_sticky", {31'b0, underrun}, 32'd1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("underrun_cleared", {31'b0, underrun}, 32'd0);
`else
        check("underrun_tied", {31'b0, underrun}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
- VGA-side requester for the shared 512x32 on-chip framebuffer RAM.
- Fetches framebuffer words over the VGA port of the memory controller.
- Drives `src`, `vga_addr` and `bus_req`, captures `rd` one cycle later, buffers the words, and unpacks them into a ready/valid pixel stream for the VGA timing block.
- Signals end of frame and flags pixel underrun.

Parameters:
- WORD_SIZE, 32, RAM data width.
- ADDR_W, 9, VGA address width into the RAM.
- PIX_BITS, 4, bits per pixel; must divide WORD_SIZE.
- FB_BASE, 0, first framebuffer word address.
- FB_WORDS, 256, words per frame; FB_BASE+FB_WORDS ≤ 512.

Ports:
- clk, input, 1, system clock (decided: one clock).
- resetn, input, 1, asynchronous active-low reset (decided: asynchronous, active-low).
- frame_start, input, 1, one-cycle pulse; starts or restarts a frame fetch.
- bus_req, output, 1, request for the RAM port.
- bus_gnt, input, 1, arbiter grant; meaningful only while bus_req is 1.
- src, output, 1, RAM source select; SRC_VGA during a granted issue cycle, else SRC_CPU.
- vga_addr, output, ADDR_W, RAM word address.
- rd, input, WORD_SIZE, RAM read data; valid the cycle after issue.
- pix_valid, output, 1, pixel available.
- pix_ready, input, 1, consumer accepts the pixel.
- pix_data, output, PIX_BITS, current pixel.
- frame_done, output, 1, one-cycle pulse after the last pixel of a frame is accepted.
- underrun, output, 1, sticky underrun flag.

Behaviour:
- Reset values:
  - pix_valid=0, pix_data=0, frame_done=0, bus_req=0, src=SRC_CPU, vga_addr=FB_BASE, underrun=0.
  - State IDLE; FIFO empty; no read in flight.
- States:
  - IDLE: frame_start → FETCH; word_idx=0; FIFO flushed.
  - FETCH: bus_req=1 iff (FIFO occupancy + in-flight + shifter-loaded) < 3.
    - An issue occurs when bus_req=1 and bus_gnt=1 in the same cycle.
    - In the issue cycle, src=SRC_VGA and vga_addr=FB_BASE+word_idx (combinational).
    - At the clock edge, word_idx increments and the in-flight flag is set.
    - When word_idx reaches FB_WORDS at an issue → DRAIN.
  - DRAIN: bus_req=0; when the last pixel is accepted, pulse frame_done for 1 cycle → IDLE.
- Read return: the cycle after an issue, rd is written into the 2-deep word FIFO. Latency from issue to rd capture is exactly 1 cycle; there is no stall path.
- Unpack:
  - A shifter holds the current word plus a pixel index 0..PIX_PER_WORD-1.
  - Pixel 0 is rd[PIX_BITS-1:0] (LSB first).
  - pix_valid=1 while the shifter is loaded.
  - A transfer occurs on pix_valid & pix_ready.
  - On transfer of the last pixel of a word, the shifter reloads from the FIFO in the same cycle if the FIFO is non-empty (no bubble).
  - If the FIFO is empty but rd is returning that cycle, rd bypasses the FIFO straight into the shifter.
- pix_data holds its value while pix_valid=1 and pix_ready=0.
- Boundary conditions:
  - bus_gnt without bus_req: ignored; src stays SRC_CPU.
  - Grant withdrawn: bus_req stays asserted and the address is held until granted.
  - frame_start mid-frame (any state):
    - Abort: FIFO flushed, shifter cleared, pix_valid=0 next cycle, word_idx=0.
    - A return arriving in the next cycle is discarded.
    - The current frame's frame_done is suppressed.
  - frame_start coincident with an issue: the new frame wins; that issue's return is discarded.
  - frame_start coincident with the last-pixel transfer: no frame_done; the new frame starts.
  - vga_addr arithmetic is modulo 2^ADDR_W.
- Underrun (see Optional Feature):
  - Set when pix_ready=1 and pix_valid=0 while state≠IDLE and the frame is not complete.
  - Cleared only by frame_start or reset.

Optional Feature:
- VGA_FB_UNDERRUN_EN defined: underrun logic as above.
- Not defined: underrun tied 0; no detection logic synthesised.

Decomposition:
- Package vga_fb_pkg holds:
  - SRC_CPU=1'b0, SRC_VGA=1'b1, shared with the memory controller's control-signal constants.
  - State encoding IDLE/FETCH/DRAIN.
  - PIX_PER_WORD = WORD_SIZE/PIX_BITS.
- Sub-module fb_word_fifo: 2-entry WORD_SIZE FIFO with push/pop/flush, full/empty, and same-cycle push+pop when full.

Test Plan:
- Reset, then idle 10 cycles → all outputs at reset values; src=SRC_CPU throughout.
- FB_WORDS=4, bus_gnt=1 always, pix_ready=1, frame_start:
  - Issues to addrs 0,1,2,3, src=SRC_VGA only in issue cycles.
  - Words 0x76543210 etc. yield pix_data 0,1,2,...,7 on consecutive cycles.
  - frame_done pulses exactly once, the cycle after the 32nd transfer.
- bus_gnt toggled 1-0-1 with pix_ready=1 → vga_addr held during denial; no skipped or duplicated words; pixel order preserved.
- pix_ready=0 for 20 cycles mid-frame → at most 3 words outstanding, bus_req drops, pix_data stable; resume with no loss.
- frame_start at word 2 of 4 → next issue is addr FB_BASE; stale return discarded; first new pixel equals word 0 pixel 0; no frame_done for the aborted frame.
- With VGA_FB_UNDERRUN_EN, bus_gnt=0 and pix_ready=1 after frame_start → underrun=1 and sticky; cleared by the next frame_start. Without the macro → underrun stays 0.
